// File: rtl/definition.sv
// rtl/definition.sv - shared accelerator definitions used by the classification head
// Provides: att_width (pooled feature width), cls_w_width (weight/bias width),
//           cls_state_t (classification head FSM states).
package definition;

  localparam int att_width   = 8;
  localparam int cls_w_width = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } cls_state_t;

endpackage

// File: rtl/cls_mac.sv
// rtl/cls_mac.sv - registered signed multiply-accumulate for the classification head
// Ports:
//   clk, rstn  : clock, synchronous active-low reset
//   clr        : first word of a row; load the term instead of adding to acc
//   en         : a valid ROM word is present this cycle
//   a, b       : signed feature and signed ROM word
//   bias_sel   : b is a bias; add it sign-extended, no multiply
//   acc        : accumulator register (row sum once the bias has been added)
module cls_mac #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int ACC_W   = 19
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      clr,
  input  logic                      en,
  input  logic signed [A_WIDTH-1:0] a,
  input  logic signed [B_WIDTH-1:0] b,
  input  logic                      bias_sel,
  output logic signed [ACC_W-1:0]   acc
);

  logic signed [A_WIDTH+B_WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]           term;
  logic signed [ACC_W-1:0]           acc_sum;

  // Both operands widened to the full product width so the multiply is exact.
  assign prod = $signed({{B_WIDTH{a[A_WIDTH-1]}}, a}) *
                $signed({{A_WIDTH{b[B_WIDTH-1]}}, b});

  assign term = bias_sel ? {{(ACC_W-B_WIDTH){b[B_WIDTH-1]}}, b}
                         : {{(ACC_W-A_WIDTH-B_WIDTH){prod[A_WIDTH+B_WIDTH-1]}}, prod};

  assign acc_sum = (clr ? '0 : acc) + term;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/cls_head.sv
// rtl/cls_head.sv - linear classification head: feature capture, per-class MAC, arg-max
// Ports:
//   clk, rstn      : clock, synchronous active-low reset
//   i_valid/i_feat : pooled feature strobe and signed feature
//   w_addr/w_data  : weight ROM address out, signed data back one cycle later
//   o_logit        : signed class logit, qualified by o_logit_valid
//   o_cls_idx      : arg-max class index, updated with the o_done pulse
//   o_busy         : high while computing or finishing
//   o_drop         : sticky, a strobe arrived while not in IDLE
module cls_head import definition::*; #(
  parameter  int N_FEAT  = 4,
  parameter  int N_CLS   = 4,
  parameter  int W_WIDTH = cls_w_width,
  localparam int ACC_W   = att_width + W_WIDTH + $clog2(N_FEAT+1),
  localparam int A_W     = $clog2(N_CLS*(N_FEAT+1)),
  localparam int I_W     = (N_CLS > 1) ? $clog2(N_CLS) : 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        i_valid,
  input  logic signed [att_width-1:0] i_feat,
  output logic        [A_W-1:0]       w_addr,
  input  logic signed [W_WIDTH-1:0]   w_data,
  output logic signed [ACC_W-1:0]     o_logit,
  output logic                        o_logit_valid,
  output logic        [I_W-1:0]       o_cls_idx,
  output logic                        o_done,
  output logic                        o_busy,
  output logic                        o_drop
);

  localparam int FC_W = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int F_W  = $clog2(N_FEAT+1);

  localparam logic [FC_W-1:0] FC_LAST = FC_W'(N_FEAT-1);
  localparam logic [F_W-1:0]  F_LAST  = F_W'(N_FEAT);
  localparam logic [A_W-1:0]  A_LAST  = A_W'(N_CLS*(N_FEAT+1)-1);
  localparam logic [I_W-1:0]  I_LAST  = I_W'(N_CLS-1);

  cls_state_t state, state_nxt;

  logic signed [att_width-1:0] feat_buf [N_FEAT];
  logic [FC_W-1:0]             fcnt;
  logic [A_W-1:0]              addr;
  logic [F_W-1:0]              fidx;

  // p_* describe the ROM word that is on w_data this cycle.
  logic                        p_valid;
  logic [F_W-1:0]              p_f;
  logic signed [att_width-1:0] a_sel;
  logic signed [ACC_W-1:0]     mac_acc;

  logic signed [ACC_W-1:0]     max_val;
  logic [I_W-1:0]              max_idx;
  logic [I_W-1:0]              lcnt;
  logic                        take;
  logic [I_W-1:0]              new_idx;
  logic                        cmp_done;

  assign w_addr  = addr;
  assign o_busy  = (state != IDLE);
  // The accumulator holds the finished row sum exactly in the strobe cycle.
  assign o_logit = o_logit_valid ? mac_acc : '0;

  always_comb begin
    a_sel = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (p_f == F_W'(i)) a_sel = feat_buf[i];
    end
  end

  cls_mac #(
    .A_WIDTH (att_width),
    .B_WIDTH (W_WIDTH),
    .ACC_W   (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (p_valid && (p_f == '0)),
    .en       (p_valid),
    .a        (a_sel),
    .b        (w_data),
    .bias_sel (p_f == F_LAST),
    .acc      (mac_acc)
  );

  // First logit of an inference always wins; later ones only if strictly greater.
  assign take    = (lcnt == '0) || (o_logit > max_val);
  assign new_idx = take ? lcnt : max_idx;

  always_comb begin
    state_nxt = state;
    o_done    = 1'b0;
    case (state)
      IDLE:    if (i_valid && (fcnt == FC_LAST)) state_nxt = COMPUTE;
      COMPUTE: if (addr == A_LAST) state_nxt = DONE;
      DONE: begin
        if (cmp_done) begin
          o_done    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && i_valid) feat_buf[fcnt] <= i_feat;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      fcnt          <= '0;
      addr          <= '0;
      fidx          <= '0;
      p_valid       <= 1'b0;
      p_f           <= '0;
      o_logit_valid <= 1'b0;
      max_val       <= '0;
      max_idx       <= '0;
      lcnt          <= '0;
      o_cls_idx     <= '0;
      cmp_done      <= 1'b0;
      o_drop        <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == IDLE && i_valid) fcnt <= (fcnt == FC_LAST) ? '0 : fcnt + 1'b1;
      if (state != IDLE && i_valid) o_drop <= 1'b1;

      if (state == COMPUTE) begin
        addr <= (addr == A_LAST) ? '0 : addr + 1'b1;
        fidx <= (fidx == F_LAST) ? '0 : fidx + 1'b1;
      end else begin
        addr <= '0;
        fidx <= '0;
      end

      p_valid       <= (state == COMPUTE);
      p_f           <= fidx;
      o_logit_valid <= p_valid && (p_f == F_LAST);

      if (o_done) cmp_done <= 1'b0;

      if (o_logit_valid) begin
        if (take) max_val <= o_logit;
        max_idx <= new_idx;
        if (lcnt == I_LAST) begin
          lcnt      <= '0;
          o_cls_idx <= new_idx;
          cmp_done  <= 1'b1;
        end else begin
          lcnt <= lcnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cls_head.sv
// tb/tb_cls_head.sv - scoreboard bench for cls_head with a 1-cycle ROM model
module tb_cls_head;
  import definition::*;

  localparam int NF    = 4;
  localparam int NC    = 4;
  localparam int WW    = 8;
  localparam int ACC_W = att_width + WW + $clog2(NF+1);
  localparam int A_W   = $clog2(NC*(NF+1));
  localparam int RW    = NC*(NF+1);

  logic                        clk = 1'b0;
  logic                        rstn = 1'b0;
  logic                        i_valid = 1'b0;
  logic signed [att_width-1:0] i_feat = '0;
  logic [A_W-1:0]              w_addr;
  logic signed [WW-1:0]        w_data;
  logic signed [ACC_W-1:0]     o_logit;
  logic                        o_logit_valid;
  logic [$clog2(NC)-1:0]       o_cls_idx;
  logic                        o_done;
  logic                        o_busy;
  logic                        o_drop;

  cls_head #(.N_FEAT(NF), .N_CLS(NC), .W_WIDTH(WW)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_valid       (i_valid),
    .i_feat        (i_feat),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .o_logit       (o_logit),
    .o_logit_valid (o_logit_valid),
    .o_cls_idx     (o_cls_idx),
    .o_done        (o_done),
    .o_busy        (o_busy),
    .o_drop        (o_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [WW-1:0] rom [RW];
  always @(posedge clk) w_data <= rom[w_addr];

  int feat [NF];
  int n_tests = 0;
  int n_fail = 0;
  int lq_val[$], lq_cyc[$], dq_idx[$], dq_cyc[$];
  int last_best = 0;
  bit drop_exp = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_logit"}, o_logit, 0);
    chk({tag, "_logit_valid"}, o_logit_valid, 0);
    chk({tag, "_cls_idx"}, o_cls_idx, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_drop"}, o_drop, 0);
  endtask

  // Reference: dot product plus bias per class, arg-max with lowest index on ties.
  task automatic push_expected(input int e);
    int s, best, best_v;
    best = 0;
    best_v = 0;
    for (int c = 0; c < NC; c++) begin
      s = int'(rom[c*(NF+1)+NF]);
      for (int f = 0; f < NF; f++) s += feat[f] * int'(rom[c*(NF+1)+f]);
      if (c == 0 || s > best_v) begin
        best_v = s;
        best = c;
      end
      lq_val.push_back(s);
      lq_cyc.push_back(e + (c+1)*(NF+1) + 1);
    end
    dq_idx.push_back(best);
    dq_cyc.push_back(e + NC*(NF+1) + 2);
    last_best = best;
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (o_logit_valid) begin
        if (lq_val.size() == 0) chk("unexpected_logit", 1, 0);
        else begin
          chk("logit_val", o_logit, lq_val.pop_front());
          chk("logit_cycle", cyc, lq_cyc.pop_front());
        end
      end
      if (o_done) begin
        if (dq_idx.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          chk("cls_idx", o_cls_idx, dq_idx.pop_front());
          chk("done_cycle", cyc, dq_cyc.pop_front());
          chk("busy_at_done", o_busy, 1);
        end
      end
    end
  end

  // Entered and left on a negedge. Returns one cycle after the o_done cycle.
  task automatic run_inf(input int gap_max, input bit inject, input bit do_reset);
    int e;
    e = 0;
    for (int f = 0; f < NF; f++) begin
      repeat ($urandom_range(gap_max, 0)) @(negedge clk);
      i_valid = 1'b1;
      i_feat  = att_width'(feat[f]);
      if (f == NF-1) begin
        e = cyc + 1;
        push_expected(e);
      end
      @(negedge clk);
      i_valid = 1'b0;
    end
    if (inject) drop_exp = 1'b1;
    while (cyc < e + NC*(NF+1) + 3) begin
      if (cyc - e < RW) chk("w_addr_step", w_addr, cyc - e);
      chk("busy", o_busy, 1);
      if (do_reset && cyc == e + 7) begin
        rstn = 1'b0;
        @(negedge clk);
        chk_zero("mid_reset");
        lq_val.delete(); lq_cyc.delete(); dq_idx.delete(); dq_cyc.delete();
        rstn = 1'b1;
        drop_exp = 1'b0;
        return;
      end
      i_valid = inject && (cyc == e+3 || cyc == e+10 || cyc == e+NC*(NF+1)+2);
      i_feat  = att_width'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("done_seen", dq_idx.size(), 0);
    chk("logits_drained", lq_val.size(), 0);
    chk("busy_after_done", o_busy, 0);
    chk("w_addr_idle", w_addr, 0);
    chk("cls_idx_hold", o_cls_idx, last_best);
    chk("drop_flag", o_drop, drop_exp);
    lq_val.delete(); lq_cyc.delete(); dq_idx.delete(); dq_cyc.delete();
  endtask

  task automatic rom_rows(input int w0, input int b0, input int wr, input int br, input bit ramp);
    for (int c = 0; c < NC; c++)
      for (int f = 0; f <= NF; f++) begin
        if (ramp) rom[c*(NF+1)+f] = (f == NF) ? WW'(0) : WW'(c+1);
        else if (c == 0) rom[c*(NF+1)+f] = (f == NF) ? WW'(b0) : WW'(w0);
        else rom[c*(NF+1)+f] = (f == NF) ? WW'(br) : WW'(wr);
      end
  endtask

  initial begin
    for (int i = 0; i < RW; i++) rom[i] = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    feat = '{1, 2, 3, 4};
    rom_rows(0, 0, 0, 0, 1'b1);
    run_inf(3, 1'b0, 1'b0);

    rom_rows(-1, -5, 0, -20, 1'b0);
    run_inf(2, 1'b0, 1'b0);

    rom_rows(0, 5, 0, 5, 1'b0);
    run_inf(0, 1'b0, 1'b0);

    feat = '{127, 127, 127, 127};
    rom_rows(-128, -128, -128, -128, 1'b0);
    run_inf(1, 1'b0, 1'b0);

    feat = '{1, 2, 3, 4};
    rom_rows(0, 0, 0, 0, 1'b1);
    run_inf(0, 1'b1, 1'b0);

    run_inf(0, 1'b0, 1'b1);
    run_inf(2, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      for (int f = 0; f < NF; f++) feat[f] = int'($urandom_range(255)) - 128;
      for (int i = 0; i < RW; i++) rom[i] = WW'($urandom_range(255));
      run_inf(3, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
